niospherisys_sw_poller: RTL and testbench

//  Avalon-MM controller that sequences the 8-bit switch input PIO. Polls the PIO data register
//  (offset 0) on a programmable period and debounces each sample. Exposes the debounced value,

---
 rtl/niospherisys_pkg.sv | 19 +
 rtl/niospherisys_sw_debounce.sv | 58 +++++
 rtl/niospherisys_sw_poller.sv | 123 ++++++++++++
 tb/tb_niospherisys_sw_poller.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/niospherisys_pkg.sv
// Shared definitions for the switch poller: register map, CTRL bit positions and poll FSM states.
package niospherisys_pkg;

  localparam logic [1:0] REG_STATE = 2'd0;
  localparam logic [1:0] REG_CTRL  = 2'd1;
  localparam logic [1:0] REG_EDGE  = 2'd2;
  localparam logic [1:0] REG_MASK  = 2'd3;

  localparam int CTRL_EN = 0;
  localparam int CTRL_IE = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_CAPT = 2'd2,
    ST_EVAL = 2'd3
  } poll_state_t;

endpackage

// File: rtl/niospherisys_sw_debounce.sv
// Debounce core: tracks a candidate value and how many consecutive polls it has been seen,
// and commits it to the debounced state once it has been stable long enough.
module niospherisys_sw_debounce #(
  parameter int DW         = 8,
  parameter int STABLE_CNT = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          eval_i,
  input  logic [DW-1:0] sample_i,
  output logic [DW-1:0] state_o,
  output logic          change_o,
  output logic [DW-1:0] diff_o
);
  localparam int CW = $clog2(STABLE_CNT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT);

  logic [DW-1:0] cand_q, cand_d;
  logic [DW-1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The commit decision uses the updated count so STABLE_CNT=1 commits on the first differing sample.
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    state_d  = state_q;
    change_o = 1'b0;
    diff_o   = '0;
    if (eval_i) begin
      if (sample_i == cand_q) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      end else begin
        cand_d = sample_i;
        cnt_d  = CW'(1);
      end
      if ((cnt_d == CNT_MAX) && (cand_d != state_q)) begin
        change_o = 1'b1;
        diff_o   = cand_d ^ state_q;
        state_d  = cand_d;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cand_q  <= '0;
      cnt_q   <= '0;
      state_q <= '0;
    end else begin
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/niospherisys_sw_poller.sv
// Switch PIO poller: periodically reads the PIO, debounces the sample, and exposes
// STATE/CTRL/EDGE/MASK plus a maskable level IRQ on an Avalon-MM slave.
module niospherisys_sw_poller
  import niospherisys_pkg::*;
#(
  parameter int DW         = 8,
  parameter int POLL_DIV   = 50000,
  parameter int STABLE_CNT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [1:0]  m_address,
  output logic        m_read,
  input  logic [31:0] m_readdata,
  input  logic [1:0]  s_address,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        irq,
  output logic [1:0]  dbg_state
);
  localparam int TW = $clog2(POLL_DIV);
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(POLL_DIV - 1);

  poll_state_t   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          en_q, en_d, ie_q, ie_d, irq_q, irq_d;
  logic [DW-1:0] mask_q, mask_d, edge_q, edge_d, sample_q;
  logic [31:0]   rdata_q, rdata_d;
  logic [DW-1:0] db_state, db_diff;
  logic          db_change;
  logic          wr_ctrl, wr_edge, wr_mask;
  logic          unused_bits;

  assign wr_ctrl = s_write && (s_address == REG_CTRL);
  assign wr_edge = s_write && (s_address == REG_EDGE);
  assign wr_mask = s_write && (s_address == REG_MASK);

  niospherisys_sw_debounce #(.DW(DW), .STABLE_CNT(STABLE_CNT)) u_debounce (
    .clk      (clk),
    .reset_n  (reset_n),
    .eval_i   (state_q == ST_EVAL),
    .sample_i (sample_q),
    .state_o  (db_state),
    .change_o (db_change),
    .diff_o   (db_diff)
  );

  // The timer free-runs while enabled so the poll period covers READ/CAPT/EVAL; enabling restarts it.
  always_comb begin
    timer_d = timer_q;
    if (wr_ctrl && s_writedata[CTRL_EN] && !en_q) timer_d = TIMER_RELOAD;
    else if (en_q) timer_d = (timer_q == '0) ? TIMER_RELOAD : timer_q - 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en_q && (timer_q == '0)) state_d = ST_READ;
      ST_READ: state_d = ST_CAPT;
      ST_CAPT: state_d = ST_EVAL;
      ST_EVAL: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A new edge in the same cycle as a W1C of that bit keeps the bit set.
  always_comb begin
    en_d   = wr_ctrl ? s_writedata[CTRL_EN] : en_q;
    ie_d   = wr_ctrl ? s_writedata[CTRL_IE] : ie_q;
    mask_d = wr_mask ? s_writedata[DW-1:0] : mask_q;
    edge_d = edge_q & ~(wr_edge ? s_writedata[DW-1:0] : '0);
    if (db_change) edge_d = edge_d | db_diff;
    irq_d  = ie_q & (|(edge_q & mask_q));
  end

  always_comb begin
    rdata_d = rdata_q;
    if (s_read) begin
      rdata_d = '0;
      case (s_address)
        REG_STATE: rdata_d[DW-1:0] = db_state;
        REG_CTRL:  rdata_d[1:0]    = {ie_q, en_q};
        REG_EDGE:  rdata_d[DW-1:0] = edge_q;
        REG_MASK:  rdata_d[DW-1:0] = mask_q;
        default:   rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      timer_q  <= TIMER_RELOAD;
      en_q     <= 1'b0;
      ie_q     <= 1'b0;
      mask_q   <= '0;
      edge_q   <= '0;
      irq_q    <= 1'b0;
      sample_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      en_q     <= en_d;
      ie_q     <= ie_d;
      mask_q   <= mask_d;
      edge_q   <= edge_d;
      irq_q    <= irq_d;
      rdata_q  <= rdata_d;
      if (state_q == ST_CAPT) sample_q <= m_readdata[DW-1:0];
    end
  end

  assign m_address   = 2'b00;
  assign m_read      = (state_q == ST_READ);
  assign s_readdata  = rdata_q;
  assign irq         = irq_q;
  assign dbg_state   = state_q;
  assign unused_bits = ^{m_readdata[31:DW], s_writedata[31:DW]};

endmodule

// File: tb/tb_niospherisys_sw_poller.sv
// Directed bench for the switch poller: instance 0 uses STABLE_CNT=3, instance 1 STABLE_CNT=1.
module tb_niospherisys_sw_poller;
  import niospherisys_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  m_address   [2];
  logic        m_read      [2];
  logic [31:0] m_readdata  [2];
  logic [1:0]  s_address   [2];
  logic        s_read      [2];
  logic        s_write     [2];
  logic [31:0] s_writedata [2];
  logic [31:0] s_readdata  [2];
  logic        irq         [2];
  logic [1:0]  dbg_state   [2];
  logic [7:0]  sw          [2];

  logic [31:0] exp_q[$];
  int n_vec = 0;
  int n_mis = 0;

  logic [7:0] bseq [5] = '{8'h01, 8'h00, 8'h01, 8'h01, 8'h01};
  logic [7:0] bexp [5] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01};

  always #5 clk = ~clk;

  niospherisys_sw_poller #(.DW(8), .POLL_DIV(4), .STABLE_CNT(3)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .m_address(m_address[0]), .m_read(m_read[0]),
    .m_readdata(m_readdata[0]), .s_address(s_address[0]), .s_read(s_read[0]),
    .s_write(s_write[0]), .s_writedata(s_writedata[0]), .s_readdata(s_readdata[0]),
    .irq(irq[0]), .dbg_state(dbg_state[0])
  );

  niospherisys_sw_poller #(.DW(8), .POLL_DIV(4), .STABLE_CNT(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .m_address(m_address[1]), .m_read(m_read[1]),
    .m_readdata(m_readdata[1]), .s_address(s_address[1]), .s_read(s_read[1]),
    .s_write(s_write[1]), .s_writedata(s_writedata[1]), .s_readdata(s_readdata[1]),
    .irq(irq[1]), .dbg_state(dbg_state[1])
  );

  // PIO model: latency-1 read with junk in the upper bits.
  always @(posedge clk) begin
    if (m_read[0]) m_readdata[0] <= {24'hA5C3E1, sw[0]};
    if (m_read[1]) m_readdata[1] <= {24'h5A3C1E, sw[1]};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int i, input logic [1:0] a, input logic [31:0] d);
    s_write[i] = 1'b1; s_address[i] = a; s_writedata[i] = d;
    tick();
    s_write[i] = 1'b0; s_writedata[i] = '0;
  endtask

  task automatic rd(input int i, input logic [1:0] a, input logic [31:0] e, input string tag);
    logic [31:0] got;
    s_read[i] = 1'b1; s_address[i] = a;
    exp_q.push_back(e);
    tick();
    s_read[i] = 1'b0;
    got = s_readdata[i];
    check(tag, got, exp_q.pop_front());
  endtask

  task automatic wait_state(input int i, input poll_state_t s, input int budget, input string tag);
    for (int n = 0; n < budget && dbg_state[i] != 2'(s); n++) tick();
    check(tag, 32'(dbg_state[i]), 32'(s));
  endtask

  task automatic count_reads(input int i, input int cycles, output int cnt);
    cnt = 0;
    for (int n = 0; n < cycles; n++) begin
      tick();
      if (m_read[i]) cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int npulse, first, second, cnt;
    for (int i = 0; i < 2; i++) begin
      s_address[i] = '0; s_read[i] = 1'b0; s_write[i] = 1'b0;
      s_writedata[i] = '0; sw[i] = '0; m_readdata[i] = '0;
    end

    // Reset values, then reset asserted while in CAPT
    tick(); tick(); tick();
    check("rst_m_read", 32'(m_read[0]), 32'd0);
    check("rst_m_addr", 32'(m_address[0]), 32'd0);
    check("rst_irq", 32'(irq[0]), 32'd0);
    check("rst_rdata", s_readdata[0], 32'd0);
    check("rst_fsm", 32'(dbg_state[0]), 32'(ST_IDLE));
    reset_n = 1'b1;
    tick();
    wr(0, REG_CTRL, 32'h1);
    wait_state(0, ST_CAPT, 12, "wait_capt");
    reset_n = 1'b0;
    #1;
    check("midrst_fsm", 32'(dbg_state[0]), 32'(ST_IDLE));
    check("midrst_m_read", 32'(m_read[0]), 32'd0);
    tick();
    check("midrst_rdata", s_readdata[0], 32'd0);
    check("midrst_irq", 32'(irq[0]), 32'd0);
    reset_n = 1'b1;
    tick();
    rd(0, REG_STATE, 32'h0, "midrst_state");
    rd(0, REG_CTRL, 32'h0, "midrst_ctrl");
    count_reads(0, 10, cnt);
    check("midrst_no_poll", 32'(cnt), 32'd0);

    // Steady 0x5A: poll cadence and commit after the third poll
    sw[0] = 8'h5A;
    wr(0, REG_CTRL, 32'h1);
    npulse = 0; first = 0; second = 0;
    for (int n = 1; n <= 16; n++) begin
      tick();
      if (m_read[0]) begin
        if (npulse == 0) first = n;
        else if (npulse == 1) second = n;
        npulse++;
      end
    end
    check("poll_first", 32'(first), 32'd4);
    check("poll_period", 32'(second - first), 32'd4);
    check("poll_count", 32'(npulse), 32'd4);
    rd(0, REG_STATE, 32'h5A, "steady_state");
    rd(0, REG_EDGE, 32'h5A, "steady_edge");
    check("steady_irq_ie0", 32'(irq[0]), 32'd0);

    // IRQ masking and W1C
    wr(0, REG_MASK, 32'h01);
    wr(0, REG_CTRL, 32'h3);
    tick(); tick();
    check("irq_mask01", 32'(irq[0]), 32'd0);
    wr(0, REG_MASK, 32'h02);
    tick();
    check("irq_mask02", 32'(irq[0]), 32'd1);
    rd(0, REG_CTRL, 32'h3, "ctrl_rb");
    rd(0, REG_MASK, 32'h02, "mask_rb");
    wr(0, REG_EDGE, 32'h02);
    tick();
    check("irq_w1c", 32'(irq[0]), 32'd0);
    rd(0, REG_EDGE, 32'h58, "edge_w1c");

    // Bouncing input from a fresh reset
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    sw[0] = 8'h00;
    wr(0, REG_CTRL, 32'h1);
    for (int k = 0; k < 5; k++) begin
      wait_state(0, ST_READ, 10, "bounce_read");
      sw[0] = bseq[k];
      wait_state(0, ST_EVAL, 10, "bounce_eval");
      tick();
      rd(0, REG_STATE, 32'(bexp[k]), "bounce_state");
    end
    rd(0, REG_EDGE, 32'h01, "bounce_edge");

    // W1C of bit3 in the EVAL cycle that sets bit3
    wait_state(0, ST_READ, 10, "w1c_read");
    sw[0] = 8'h09;
    wr(0, REG_EDGE, 32'hFF);
    for (int k = 0; k < 3; k++) begin
      wait_state(0, ST_EVAL, 10, "w1c_eval");
      if (k < 2) tick();
      else wr(0, REG_EDGE, 32'h08);
    end
    rd(0, REG_EDGE, 32'h08, "w1c_set_wins");
    rd(0, REG_STATE, 32'h09, "w1c_state");
    wr(0, REG_EDGE, 32'h08);
    rd(0, REG_EDGE, 32'h00, "w1c_clear");

    // STABLE_CNT=1 with EN cleared during READ
    sw[1] = 8'h33;
    wr(1, REG_CTRL, 32'h1);
    wait_state(1, ST_READ, 10, "en_off_read");
    wr(1, REG_CTRL, 32'h0);
    check("en_off_capt", 32'(dbg_state[1]), 32'(ST_CAPT));
    tick();
    check("en_off_eval", 32'(dbg_state[1]), 32'(ST_EVAL));
    tick();
    check("en_off_idle", 32'(dbg_state[1]), 32'(ST_IDLE));
    rd(1, REG_STATE, 32'h33, "sc1_state");
    rd(1, REG_EDGE, 32'h33, "sc1_edge");
    count_reads(1, 20, cnt);
    check("en_off_halt", 32'(cnt), 32'd0);
    check("sc1_irq", 32'(irq[1]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
